// File: rtl/spi_master_burst.sv
// SPI master with chained-word frames, automatic chip select and all four CPOL/CPHA modes.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from the internal mosi instead of miso.
module spi_master_burst #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int NUM_CS = 1,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic [NUM_CS-1:0] cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam int KW = EW - 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HALF, EDGE, WAIT, HOLD} state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  cnt, div_q;
    logic [EW-1:0]     edge_idx, idx_inc;
    logic              cpol_q, cpha_q, lsb_q, last_q;
    logic [CS_W-1:0]   cs_q;
    logic [DATA_W-1:0] tx_q, rx_sh, rx_nx;
    logic              sclk_q, mosi_q;
    logic              accept, cnt_done, last_edge, edge_go, drive, sample, ser_in;
    logic [KW-1:0]     tx_k, rx_k;

    // Maps wire-order bit k to its position in the word.
    function automatic logic [KW-1:0] bit_pos(input logic [KW-1:0] k, input logic lsb);
        return lsb ? k : (KW'(DATA_W - 1) - k);
    endfunction

    // A word moves on the cycle where tx_valid && tx_ready; tx_data/tx_last must hold until then.
    assign tx_ready  = ((state == IDLE) || (state == WAIT)) && !sys_rst;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state != IDLE);
    assign cnt_done  = (cnt == '0);
    assign last_edge = (edge_idx == LAST_EDGE);
    assign idx_inc   = edge_idx + EW'(1);
    assign edge_go   = (state == HALF) && cnt_done;
    assign drive     = (edge_idx[0] ^ cpha_q) && !last_edge;
    assign sample    = (edge_idx[0] == cpha_q);
    assign tx_k      = cpha_q ? edge_idx[EW-1:1] : idx_inc[EW-1:1];
    assign rx_k      = edge_idx[EW-1:1];
    assign sclk      = (state == IDLE) ? (cpol && !sys_rst) : sclk_q;
    assign mosi      = mosi_q;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign ser_in = mosi_q;
`else
    assign ser_in = miso;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = SETUP;
            SETUP: if (cnt_done) state_nx = HALF;
            HALF:  if (cnt_done) state_nx = EDGE;
            EDGE: begin
                if (last_edge) state_nx = last_q ? HOLD : WAIT;
                else           state_nx = HALF;
            end
            WAIT:  if (accept) state_nx = HALF;
            HOLD:  if (cnt_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_nx = rx_sh;
        if ((state == EDGE) && sample) rx_nx[bit_pos(rx_k, lsb_q)] = ser_in;
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if ((state != IDLE) && (cs_q == CS_W'(i))) cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt      <= '0;
            div_q    <= '0;
            edge_idx <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            last_q   <= 1'b0;
            cs_q     <= '0;
            tx_q     <= '0;
            rx_sh    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            // Entering a timed state reloads the half-period counter; the first one uses the live divider.
            if (state_nx != state)  cnt <= (state == IDLE) ? clk_div : div_q;
            else if (!cnt_done)     cnt <= cnt - DIV_W'(1);

            if ((state == IDLE) && accept) begin
                tx_q     <= tx_data;
                last_q   <= tx_last;
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                lsb_q    <= lsb_first;
                div_q    <= clk_div;
                cs_q     <= cs_sel;
                edge_idx <= '0;
                sclk_q   <= cpol;
                if (!cpha) mosi_q <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            end

            if ((state == WAIT) && accept) begin
                tx_q     <= tx_data;
                last_q   <= tx_last;
                edge_idx <= '0;
                if (!cpha_q) mosi_q <= lsb_q ? tx_data[0] : tx_data[DATA_W-1];
            end

            if (edge_go) begin
                sclk_q <= ~sclk_q;
                if (drive) mosi_q <= tx_q[bit_pos(tx_k, lsb_q)];
            end

            if (state == EDGE) begin
                edge_idx <= idx_inc;
                rx_sh    <= rx_nx;
                if (last_edge) begin
                    rx_data  <= rx_nx;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: SPI slave model, rx scoreboard, frame timing monitor.
module tb_spi_master_burst;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int NUM_CS = 3;
    localparam int CS_W   = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cpol, cpha, lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic              tx_valid, tx_ready, tx_last;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic              rx_valid, busy, sclk, mosi;
    logic              miso = 1'b0;
    logic [NUM_CS-1:0] cs_n;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] wire_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int edge_cnt, rv_cnt, cs_fall_cnt, cs_rise_cnt;
    int cs_fall_cyc, cs_rise_cyc, rv_cyc, acc_cyc;
    int edge_t[0:63];
    logic [NUM_CS-1:0] cs_fall_val;
    logic [7:0] slv_word = 8'h00;

    spi_master_burst #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .cs_n(cs_n),
        .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    // Clock and cycle counter
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame monitor and rx scoreboard
    logic mon_sclk_prev = 1'b0;
    logic mon_cs_prev   = 1'b0;
    always @(negedge sys_clk) begin : monitor
        logic cs_low;
        cs_low = (cs_n != '1);
        if (!sys_rst) begin
            if (busy && (sclk !== mon_sclk_prev)) begin
                edge_cnt++;
                if (edge_cnt < 64) edge_t[edge_cnt] = cyc;
            end
            if (cs_low && !mon_cs_prev) begin
                cs_fall_cnt++;
                cs_fall_cyc = cyc;
                cs_fall_val = cs_n;
            end
            if (!cs_low && mon_cs_prev) begin
                cs_rise_cnt++;
                cs_rise_cyc = cyc;
            end
            if (tx_ready && busy) begin
                check("wait_on_word_boundary", edge_cnt % 16, 0);
                check("wait_sclk_idle", sclk, cpol);
            end
            if (rx_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rx_unexpected: got rx_data 0x%0h, expected no rx_valid", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
        end
        mon_sclk_prev = sclk;
        mon_cs_prev   = cs_low;
    end

    // SPI slave model: MSB-first on the wire, mode taken from the bench cpol/cpha
    logic slv_sclk_prev = 1'b0;
    logic slv_sel_prev  = 1'b0;
    logic [7:0] srx = 8'h00;
    int sb = 0;
    int scnt = 0;
    always @(negedge sys_clk) begin : slave
        logic sel_now, lead;
        sel_now = (cs_n != '1);
        if (!sel_now) begin
            miso = 1'b0;
            sb   = 0;
            scnt = 0;
        end else if (!slv_sel_prev) begin
            sb   = 0;
            scnt = 0;
            miso = cpha ? 1'b0 : slv_word[7];
        end else if (sclk !== slv_sclk_prev) begin
            lead = (sclk !== cpol);
            if (lead ^ cpha) begin
                srx = {srx[6:0], mosi};
                scnt++;
                if (scnt == 8) begin
                    scnt = 0;
                    if (wire_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mosi_unexpected: got word 0x%0h, expected none", srx);
                    end else begin
                        check("mosi_word", srx, wire_q.pop_front());
                    end
                end
            end else if (cpha) begin
                miso = slv_word[7-sb];
                sb   = (sb + 1) % 8;
            end else begin
                sb   = (sb + 1) % 8;
                miso = slv_word[7-sb];
            end
        end
        slv_sel_prev  = sel_now;
        slv_sclk_prev = sclk;
    end

    // Driver tasks (called at a negedge)
    task automatic send(input logic [7:0] data, input logic last,
                        input logic has_rx, input logic [7:0] exp_rx,
                        input logic has_wire, input logic [7:0] exp_wire);
        int guard;
        tx_data  = data;
        tx_last  = last;
        tx_valid = 1'b1;
        guard = 0;
        while (!tx_ready && guard < 1000) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_checks++;
            $display("FAIL send_timeout: tx_ready stayed 0, expected 1");
        end
        acc_cyc = cyc;
        if (has_rx)   exp_q.push_back(exp_rx);
        if (has_wire) wire_q.push_back(exp_wire);
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            $display("FAIL idle_timeout: busy stayed 1, expected 0");
        end
        repeat (2) @(negedge sys_clk);
        check("rx_all_seen", exp_q.size(), 0);
    endtask

    task automatic clear_meas();
        edge_cnt    = 0;
        rv_cnt      = 0;
        cs_fall_cnt = 0;
        cs_rise_cnt = 0;
    endtask

    initial begin
        int guard;
        sys_rst = 1'b1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = 16'd1; cs_sel = 2'd0;
        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        clear_meas();
        repeat (3) @(negedge sys_clk);

        check("rst_cs_n", cs_n, 3'b111);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_sclk_cpol", sclk, 1);
        cpol = 1'b0;
        @(negedge sys_clk);

        // Mode 0 single word, H = 2
        clear_meas();
        slv_word = 8'h3C;
        send(8'hA5, 1'b1, 1'b1, 8'h3C, 1'b1, 8'hA5);
        wait_idle();
        check("m0_edges", edge_cnt, 16);
        check("m0_rx_pulses", rv_cnt, 1);
        check("m0_cs_pattern", cs_fall_val, 3'b110);
        check("m0_accept_to_cs", cs_fall_cyc - acc_cyc, 1);
        check("m0_cs_to_edge", edge_t[1] - cs_fall_cyc, 4);
        check("m0_edge_spacing", edge_t[2] - edge_t[1], 3);
        check("m0_edge_to_rx_valid", rv_cyc - edge_t[16], 1);
        check("m0_edge_to_cs_high", cs_rise_cyc - edge_t[16], 3);

        // All four modes, clk_div = 0
        for (int m = 0; m < 4; m++) begin
            cpol = (m >= 2);
            cpha = (m % 2 == 1);
            clk_div = 16'd0;
            cs_sel = 2'd1;
            @(negedge sys_clk);
            check("mode_idle_sclk", sclk, cpol);
            clear_meas();
            slv_word = 8'h81;
            send(8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 8'h81);
            wait_idle();
            check("mode_edges", edge_cnt, 16);
            check("mode_edge_spacing", edge_t[2] - edge_t[1], 2);
            check("mode_cs_pattern", cs_fall_val, 3'b101);
        end

        // LSB-first
        cpol = 1'b0; cpha = 1'b0; clk_div = 16'd1; cs_sel = 2'd0; lsb_first = 1'b1;
        @(negedge sys_clk);
        slv_word = 8'h80;
        send(8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 8'h80);
        wait_idle();
        cpol = 1'b1; cpha = 1'b1;
        @(negedge sys_clk);
        slv_word = 8'h12;
        send(8'h0F, 1'b1, 1'b1, 8'h48, 1'b1, 8'hF0);
        wait_idle();
        lsb_first = 1'b0;

        // Three-word burst in mode 1 on cs 2; mid-frame config changes must not apply
        cpol = 1'b0; cpha = 1'b1; clk_div = 16'd1; cs_sel = 2'd2;
        @(negedge sys_clk);
        clear_meas();
        slv_word = 8'h5A;
        send(8'h11, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h11);
        clk_div = 16'd7;
        lsb_first = 1'b1;
        send(8'h22, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h22);
        send(8'h33, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h33);
        wait_idle();
        check("burst_edges", edge_cnt, 48);
        check("burst_rx_pulses", rv_cnt, 3);
        check("burst_cs_falls", cs_fall_cnt, 1);
        check("burst_cs_rises", cs_rise_cnt, 1);
        check("burst_cs_pattern", cs_fall_val, 3'b011);
        check("burst_wait_gap1", edge_t[17] - edge_t[16], 4);
        check("burst_wait_gap2", edge_t[33] - edge_t[32], 4);
        check("burst_div_held", edge_t[18] - edge_t[17], 3);
        clk_div = 16'd1;
        lsb_first = 1'b0;

        // Reset on the seventh edge, then a clean word
        cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
        @(negedge sys_clk);
        clear_meas();
        slv_word = 8'hFF;
        send(8'h96, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        guard = 0;
        while (edge_cnt < 7 && guard < 500) begin
            @(negedge sys_clk);
            guard++;
        end
        check("rst_mid_edge_reached", edge_cnt, 7);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_mid_cs_n", cs_n, 3'b111);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_sclk", sclk, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_mid_ready", tx_ready, 1);
        clear_meas();
        slv_word = 8'h0F;
        send(8'hF0, 1'b1, 1'b1, 8'h0F, 1'b1, 8'hF0);
        wait_idle();
        check("after_rst_edges", edge_cnt, 16);
        check("after_rst_rx_pulses", rv_cnt, 1);

        // cs_sel beyond NUM_CS: no chip select, frame still runs
        cs_sel = 2'd3;
        @(negedge sys_clk);
        clear_meas();
        send(8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
        wait_idle();
        check("nocs_cs_falls", cs_fall_cnt, 0);
        check("nocs_edges", edge_cnt, 16);
        check("nocs_rx_pulses", rv_cnt, 1);

        check("mosi_all_seen", wire_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
